// File: rtl/stage_tap_ctrl.sv
// Stage tap controller: serial tap words -> whole-row writes; start -> rows 0..DEPTH-1 via 2-entry FIFO (start to taps_valid 3 cycles).
// Reads stop at 2 outstanding rows under taps_ready backpressure. STAGE_TAP_CTRL_CHECKSUM_EN adds load_checksum.
module stage_tap_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic         head_vld_o,
    output logic [W-1:0] head_dat_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] e0_q, e1_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
        end else begin
            case ({push_i, pop_i})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        e0_q <= e1_q;
                        e1_q <= push_dat_i;
                    end else begin
                        e0_q <= push_dat_i;
                    end
                end
                2'b01: begin
                    e0_q    <= e1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) e0_q <= push_dat_i;
                    else                 e1_q <= push_dat_i;
                    count_q <= count_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign head_vld_o = (count_q != 2'd0);
    assign head_dat_o = e0_q;
    assign count_o    = count_q;
endmodule

module stage_tap_ctrl #(
    parameter int LANES  = 6,
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [WIDTH-1:0]       load_data,
    output logic                   load_done,
    input  logic                   start,
    output logic                   busy,
    output logic                   run_done,
    output logic                   tap_wr_en,
    output logic [ADDR_W-1:0]      tap_wr_addr,
    output logic [LANES*WIDTH-1:0] tap_wr_data,
    output logic [2:0]             tap_sub_addr,
    output logic [WIDTH-1:0]       tap_sub_data,
    output logic                   tap_rd_en,
    output logic [ADDR_W-1:0]      tap_rd_addr,
    input  logic [LANES*WIDTH-1:0] tap_rd_data,
    output logic                   taps_valid,
    input  logic                   taps_ready,
    output logic [LANES*WIDTH-1:0] taps_data,
    output logic [ADDR_W-1:0]      taps_row
`ifdef STAGE_TAP_CTRL_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]       load_checksum
`endif
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ROW_W  = LANES * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN} state_t;

    state_t                state_q;
    logic [LANE_W-1:0]     lane_q;
    logic [ADDR_W-1:0]     row_q;
    logic [ADDR_W:0]       rd_row_q;
    logic [ROW_W-1:0]      row_buf_q;
    logic                  rd_vld_q;
    logic [ADDR_W-1:0]     rd_vld_row_q;
    logic                  load_done_q;

    logic                  accept_d;
    logic                  issue_d;
    logic                  pop_d;
    logic [1:0]            fifo_cnt;
    logic [2:0]            outstanding_d;
    logic [ADDR_W+ROW_W-1:0] head_dat;

`ifdef STAGE_TAP_CTRL_CHECKSUM_EN
    logic [WIDTH-1:0]      csum_q;
    assign load_checksum = csum_q;
`endif

    assign load_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign accept_d   = load_valid && load_ready;
    assign pop_d      = taps_valid && taps_ready;

    // The slot freed by this cycle's pop is reusable at once; without it a pass cannot sustain one row per cycle.
    assign outstanding_d = 3'(fifo_cnt) + 3'(rd_vld_q) - 3'(pop_d);
    assign issue_d = (state_q == S_RUN) && (rd_row_q < (ADDR_W+1)'(DEPTH)) && (outstanding_d < 3'd2);

    assign run_done     = (state_q == S_RUN) && pop_d && (taps_row == ADDR_W'(DEPTH - 1));
    assign busy         = (state_q != S_IDLE);
    assign load_done    = load_done_q;
    assign tap_wr_en    = (state_q == S_WRITE);
    assign tap_wr_addr  = row_q;
    assign tap_wr_data  = row_buf_q;
    assign tap_sub_addr = 3'd7;
    assign tap_sub_data = '0;
    assign tap_rd_en    = issue_d;
    assign tap_rd_addr  = rd_row_q[ADDR_W-1:0];
    assign taps_row     = head_dat[ROW_W +: ADDR_W];
    assign taps_data    = head_dat[ROW_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            row_q        <= '0;
            rd_row_q     <= '0;
            row_buf_q    <= '0;
            rd_vld_q     <= 1'b0;
            rd_vld_row_q <= '0;
            load_done_q  <= 1'b0;
`ifdef STAGE_TAP_CTRL_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            load_done_q  <= 1'b0;
            rd_vld_q     <= issue_d;
            rd_vld_row_q <= rd_row_q[ADDR_W-1:0];
            if (issue_d) rd_row_q <= rd_row_q + 1'b1;

            case (state_q)
                S_IDLE, S_LOAD: begin
                    // Load wins over start; the accepting IDLE cycle is word 0 of the row.
                    if (accept_d) begin
                        row_buf_q[lane_q*WIDTH +: WIDTH] <= load_data;
`ifdef STAGE_TAP_CTRL_CHECKSUM_EN
                        csum_q <= (state_q == S_IDLE) ? load_data : csum_q + load_data;
`endif
                        if (lane_q == LANE_W'(LANES - 1)) begin
                            lane_q  <= '0;
                            state_q <= S_WRITE;
                        end else begin
                            lane_q  <= lane_q + 1'b1;
                            state_q <= S_LOAD;
                        end
                    end else if (state_q == S_IDLE && start) begin
                        state_q  <= S_RUN;
                        rd_row_q <= '0;
                    end
                end
                S_WRITE: begin
                    if (row_q == ADDR_W'(DEPTH - 1)) begin
                        row_q       <= '0;
                        load_done_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        row_q   <= row_q + 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_RUN: begin
                    if (run_done) begin
                        rd_row_q <= '0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    stage_tap_fifo2 #(
        .W (ADDR_W + ROW_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (rd_vld_q),
        .push_dat_i ({rd_vld_row_q, tap_rd_data}),
        .pop_i      (pop_d),
        .head_vld_o (taps_valid),
        .head_dat_o (head_dat),
        .count_o    (fifo_cnt)
    );
endmodule
